pipe_vr: RTL

Parametrised multi-stage valid/ready register pipeline, the configurable successor to the single forward-only slice. It chains `P_STAGES` identical slices, each of which can break the forward path, the reverse path, or both. It also adds a synchronous flush and an occupancy count. It sits on any streaming interface where timing closure needs registered `valid`/`data`, registered `ready`, or both, across long routes.

---
 rtl/pipe_vr_pkg.sv | 14 +
 rtl/pipe_vr_stage.sv | 125 ++++++++++++
 rtl/pipe_vr.sv | 58 +++++
 3 files changed

// File: rtl/pipe_vr_pkg.sv
// Shared types and helpers for the configurable valid/ready pipeline.
package pipe_vr_pkg;

  typedef enum logic [1:0] {
    MODE_FWD,
    MODE_REV,
    MODE_FULL
  } mode_e;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_vr_stage.sv
// One valid/ready slice: forward register, reverse (skid) register, or both.
module pipe_vr_stage
  import pipe_vr_pkg::*;
#(
  parameter int    P_DATA_WIDTH = 32,
  parameter mode_e P_MODE       = MODE_FULL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [P_DATA_WIDTH-1:0] data_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [P_DATA_WIDTH-1:0] data_o,
  input  logic                    ready_i,
  output logic [1:0]              count_o
);

  if (P_MODE == MODE_FWD) begin : g_fwd
    logic                    v_q, v_d;
    logic [P_DATA_WIDTH-1:0] d_q, d_d;

    // ready stays combinational through this slice
    assign ready_o = ready_i || !v_q;
    assign valid_o = v_q;
    assign data_o  = d_q;
    assign count_o = {1'b0, v_q};

    always_comb begin
      v_d = (valid_i || !ready_o) && !flush_i;
      d_d = ready_o ? data_i : d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

  end else if (P_MODE == MODE_REV) begin : g_rev
    logic                    s_v_q, s_v_d;
    logic [P_DATA_WIDTH-1:0] s_d_q, s_d_d;

    assign ready_o = !s_v_q;
    assign valid_o = s_v_q || valid_i;
    assign data_o  = s_v_q ? s_d_q : data_i;
    assign count_o = {1'b0, s_v_q};

    always_comb begin
      s_v_d = s_v_q;
      s_d_d = s_d_q;
      if (flush_i || ready_i) begin
        s_v_d = 1'b0;
      end else if (valid_i && !s_v_q) begin
        s_v_d = 1'b1;
        s_d_d = data_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_v_q <= 1'b0;
        s_d_q <= '0;
      end else begin
        s_v_q <= s_v_d;
        s_d_q <= s_d_d;
      end
    end

  end else begin : g_full
    logic                    m_v_q, m_v_d, s_v_q, s_v_d;
    logic [P_DATA_WIDTH-1:0] m_d_q, m_d_d, s_d_q, s_d_d;

    assign ready_o = !s_v_q;
    assign valid_o = m_v_q;
    assign data_o  = m_d_q;
    assign count_o = {1'b0, m_v_q} + {1'b0, s_v_q};

    // ready_o is low whenever the skid is full, so skid->main and
    // input->skid can never happen on the same edge.
    always_comb begin
      m_v_d = m_v_q;
      m_d_d = m_d_q;
      s_v_d = s_v_q;
      s_d_d = s_d_q;
      if (!m_v_q || ready_i) begin
        if (s_v_q) begin
          m_v_d = 1'b1;
          m_d_d = s_d_q;
        end else begin
          m_v_d = valid_i;
          if (valid_i) m_d_d = data_i;
        end
        s_v_d = 1'b0;
      end else if (valid_i && !s_v_q) begin
        s_v_d = 1'b1;
        s_d_d = data_i;
      end
      if (flush_i) begin
        m_v_d = 1'b0;
        s_v_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_v_q <= 1'b0;
        m_d_q <= '0;
        s_v_q <= 1'b0;
        s_d_q <= '0;
      end else begin
        m_v_q <= m_v_d;
        m_d_q <= m_d_d;
        s_v_q <= s_v_d;
        s_d_q <= s_d_d;
      end
    end
  end

endmodule

// File: rtl/pipe_vr.sv
// Chain of P_STAGES valid/ready slices with synchronous flush and occupancy count.
module pipe_vr
  import pipe_vr_pkg::*;
#(
  parameter int    P_DATA_WIDTH = 32,
  parameter int    P_STAGES     = 1,
  parameter mode_e P_MODE       = MODE_FULL,
  localparam int   OCC_W        = occ_width(P_STAGES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic [P_DATA_WIDTH-1:0] data_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [P_DATA_WIDTH-1:0] data_out,
  input  logic                    ready_out,
  output logic [OCC_W-1:0]        occupancy
);

  logic                    valid_c [P_STAGES+1];
  logic [P_DATA_WIDTH-1:0] data_c  [P_STAGES+1];
  logic                    ready_c [P_STAGES+1];
  logic [1:0]              cnt     [P_STAGES];
  logic [OCC_W-1:0]        occ_sum [P_STAGES+1];

  // flush blocks both external handshakes; slices clear their own valids
  assign valid_c[0]        = valid_in && !flush;
  assign data_c[0]         = data_in;
  assign ready_in          = ready_c[0] && !flush;
  assign ready_c[P_STAGES] = ready_out && !flush;
  assign valid_out         = valid_c[P_STAGES] && !flush;
  assign data_out          = data_c[P_STAGES];
  assign occ_sum[0]        = '0;
  assign occupancy         = occ_sum[P_STAGES];

  for (genvar gi = 0; gi < P_STAGES; gi++) begin : g_stage
    pipe_vr_stage #(
      .P_DATA_WIDTH(P_DATA_WIDTH),
      .P_MODE      (P_MODE)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush_i(flush),
      .valid_i(valid_c[gi]),
      .data_i (data_c[gi]),
      .ready_o(ready_c[gi]),
      .valid_o(valid_c[gi+1]),
      .data_o (data_c[gi+1]),
      .ready_i(ready_c[gi+1]),
      .count_o(cnt[gi])
    );

    assign occ_sum[gi+1] = occ_sum[gi] + OCC_W'(cnt[gi]);
  end

endmodule
